// File: rtl/alu_op_sequencer.sv
// Command sequencer for a 4-bit combinational ALU. It registers the operands and selects,
// waits a programmable settle time, then captures the 5-bit result for a downstream handshake.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic               cmd_chain,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic               alu_s2,
  output logic               alu_s1,
  output logic               alu_s0,
  input  logic [4:0]         alu_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [4:0]         res_y,
  output logic [2:0]         res_op,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OUT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_settle;
  logic [3:0]         r_alu_a;
  logic [3:0]         r_alu_b;
  logic [2:0]         r_sel;
  logic [4:0]         r_res_y;
  logic [2:0]         r_res_op;
  logic               r_res_valid;
  logic [COUNT_W-1:0] r_count;
  // Only acc[3:0] is ever consumed (the carry bit is dropped on chaining), so only that is stored.
  logic [3:0]         r_acc;
  logic               r_acc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_settle    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_sel       <= '0;
      r_res_y     <= '0;
      r_res_op    <= '0;
      r_res_valid <= 1'b0;
      r_count     <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_alu_a  <= (cmd_chain && r_acc_valid) ? r_acc : cmd_a;
            r_alu_b  <= cmd_b;
            r_sel    <= cmd_op;
            r_settle <= SETTLE_LOAD;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle != 4'd0) begin
            r_settle <= r_settle - 4'd1;
          end else begin
            r_res_y     <= alu_y;
            r_res_op    <= r_sel;
            r_acc       <= alu_y[3:0];
            r_acc_valid <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_count     <= r_count + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s2    = r_sel[2];
  assign alu_s1    = r_sel[1];
  assign alu_s0    = r_sel[0];
  assign res_valid = r_res_valid;
  assign res_y     = r_res_y;
  assign res_op    = r_res_op;
  assign op_count  = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 uses SETTLE_CYCLES=1/COUNT_W=2, instance 1 uses SETTLE_CYCLES=4/COUNT_W=8.
// Each instance drives a behavioural ALU, and a transaction-level model predicts the results.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic       cmd_chain [2];
  logic       res_ready [2];
  logic [2:0] cmd_op    [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic       cmd_ready [2];
  logic       busy      [2];
  logic       res_valid [2];
  logic       s2 [2];
  logic       s1 [2];
  logic       s0 [2];
  logic [3:0] alu_a [2];
  logic [3:0] alu_b [2];
  logic [4:0] alu_y [2];
  logic [4:0] res_y [2];
  logic [2:0] res_op [2];
  logic [1:0] oc0;
  logic [7:0] oc1;

  int checks = 0;
  int fails  = 0;

  int         settle [2] = '{1, 4};
  int         cmod   [2] = '{4, 256};
  logic [3:0] macc   [2];
  bit         maccv  [2];
  int         mcount [2];

  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {a, 1'b0};
      3'b010:  return {1'b0, a} + 5'd1;
      3'b011:  return {1'b0, a} - {1'b0, b};
      3'b100:  return {1'b0, a & b};
      3'b101:  return {1'b0, a ^ b};
      3'b110:  return {1'b0, ~a};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign alu_y[0] = alu_fn(alu_a[0], alu_b[0], {s2[0], s1[0], s0[0]});
  assign alu_y[1] = alu_fn(alu_a[1], alu_b[1], {s2[1], s1[1], s0[1]});

  alu_op_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_chain(cmd_chain[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s2(s2[0]), .alu_s1(s1[0]), .alu_s0(s0[0]),
    .alu_y(alu_y[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_y(res_y[0]),
    .res_op(res_op[0]), .busy(busy[0]), .op_count(oc0)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4), .COUNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_chain(cmd_chain[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s2(s2[1]), .alu_s1(s1[1]), .alu_s0(s0[1]),
    .alu_y(alu_y[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_y(res_y[1]),
    .res_op(res_op[1]), .busy(busy[1]), .op_count(oc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] count_of(input int d);
    return (d == 0) ? {6'b0, oc0} : oc1;
  endfunction

  // One full transaction on instance d with inline checks of every phase.
  task automatic run_cmd(input int d, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input bit chain, input int stall, input bit early);
    logic [3:0] ea;
    logic [4:0] ey;
    int n;
    @(negedge clk);
    for (int i = 0; i < 20 && cmd_ready[d] !== 1'b1; i++) @(negedge clk);
    checks++;
    if (cmd_ready[d] !== 1'b1) begin
      fails++; $display("FAIL wait_ready d=%0d: cmd_ready=%b required 1", d, cmd_ready[d]);
    end
    ea = (chain && maccv[d]) ? macc[d] : a;
    ey = alu_fn(ea, b, op);
    cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_chain[d] = chain;
    res_ready[d] = early;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
      fails++; $display("FAIL accept d=%0d: cmd_ready=%b busy=%b required 0/1", d, cmd_ready[d], busy[d]);
    end
    checks++;
    if (alu_a[d] !== ea || alu_b[d] !== b || {s2[d], s1[d], s0[d]} !== op) begin
      fails++; $display("FAIL alu_drive d=%0d: a=%h b=%h s=%b required a=%h b=%h s=%b",
                        d, alu_a[d], alu_b[d], {s2[d], s1[d], s0[d]}, ea, b, op);
    end
    @(negedge clk);
    cmd_valid[d] = 1'b0; cmd_a[d] = 4'($urandom); cmd_chain[d] = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      checks++;
      if (alu_a[d] !== ea || alu_b[d] !== b || {s2[d], s1[d], s0[d]} !== op) begin
        fails++; $display("FAIL alu_hold d=%0d cyc=%0d: a=%h b=%h required a=%h b=%h", d, n, alu_a[d], alu_b[d], ea, b);
      end
    end while (res_valid[d] !== 1'b1 && n < 40);
    checks++;
    if (n !== settle[d] || res_valid[d] !== 1'b1) begin
      fails++; $display("FAIL latency d=%0d: res_valid after %0d cycles required %0d", d, n, settle[d]);
    end
    checks++;
    if (res_y[d] !== ey || res_op[d] !== op) begin
      fails++; $display("FAIL result d=%0d: res_y=%h res_op=%b required %h %b", d, res_y[d], res_op[d], ey, op);
    end
    macc[d] = ey[3:0];
    maccv[d] = 1'b1;
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        cmd_valid[d] = 1'b1; cmd_a[d] = 4'($urandom); cmd_op[d] = 3'($urandom);
        @(posedge clk); #1;
        checks++;
        if (res_valid[d] !== 1'b1 || res_y[d] !== ey || res_op[d] !== op || cmd_ready[d] !== 1'b0) begin
          fails++; $display("FAIL stall d=%0d: valid=%b y=%h op=%b rdy=%b required 1 %h %b 0",
                            d, res_valid[d], res_y[d], res_op[d], cmd_ready[d], ey, op);
        end
      end
      @(negedge clk);
      cmd_valid[d] = 1'b0; res_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    mcount[d] = (mcount[d] + 1) % cmod[d];
    checks++;
    if (res_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      fails++; $display("FAIL handoff d=%0d: valid=%b rdy=%b busy=%b required 0 1 0", d, res_valid[d], cmd_ready[d], busy[d]);
    end
    checks++;
    if (count_of(d) !== 8'(mcount[d])) begin
      fails++; $display("FAIL op_count d=%0d: got %0d required %0d", d, count_of(d), mcount[d]);
    end
    @(negedge clk);
    res_ready[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int d);
    checks++;
    if (alu_a[d] !== 4'h0 || alu_b[d] !== 4'h0 || {s2[d], s1[d], s0[d]} !== 3'b000 ||
        res_y[d] !== 5'h00 || res_op[d] !== 3'b000 || count_of(d) !== 8'h00 ||
        res_valid[d] !== 1'b0 || busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
      fails++; $display("FAIL reset_state d=%0d: a=%h b=%h y=%h op=%b cnt=%0d v=%b busy=%b rdy=%b",
                        d, alu_a[d], alu_b[d], res_y[d], res_op[d], count_of(d), res_valid[d], busy[d], cmd_ready[d]);
    end
  endtask

  task automatic apply_reset(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0;
    #1;
    maccv[d] = 1'b0; mcount[d] = 0;
    check_reset_outputs(d);
    @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_chain[d] = 1'b0; res_ready[d] = 1'b0;
      cmd_op[d] = '0; cmd_a[d] = '0; cmd_b[d] = '0;
      rst_n[d] = 1'b0; maccv[d] = 1'b0; mcount[d] = 0; macc[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outputs(d);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    // Idle with no handshake: ALU drive must not move.
    for (int d = 0; d < 2; d++) begin cmd_a[d] = 4'h9; cmd_b[d] = 4'h6; cmd_op[d] = 3'b101; end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outputs(d);
  endtask

  task automatic test_basic_add();
    run_cmd(0, 3'b000, 4'hF, 4'h1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_chain();
    run_cmd(0, 3'b010, 4'h7, 4'h0, 1'b0, 0, 1'b1);
    run_cmd(0, 3'b001, 4'h3, 4'h8, 1'b1, 0, 1'b1);
    run_cmd(0, 3'b000, 4'h5, 4'h1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd(0, 3'b011, 4'h2, 4'h9, 1'b0, 5, 1'b0);
    run_cmd(1, 3'b100, 4'hC, 4'hA, 1'b0, 5, 1'b0);
  endtask

  task automatic test_settle_timing();
    run_cmd(1, 3'b111, 4'hA, 4'h5, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_settle();
    @(negedge clk);
    cmd_valid[1] = 1'b1; cmd_op[1] = 3'b000; cmd_a[1] = 4'h6; cmd_b[1] = 4'h7; cmd_chain[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (busy[1] !== 1'b1) begin
      fails++; $display("FAIL pre_reset_busy: busy=%b required 1", busy[1]);
    end
    rst_n[1] = 1'b0;
    #1;
    maccv[1] = 1'b0; mcount[1] = 0;
    check_reset_outputs(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    run_cmd(1, 3'b010, 4'h2, 4'h0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_counter_wrap();
    apply_reset(0);
    for (int i = 0; i < 5; i++) run_cmd(0, 3'b101, 4'(i), 4'h3, 1'b0, 0, 1'b1);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom_range(0, 1), 3'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_chain();
    test_backpressure();
    test_settle_timing();
    test_reset_mid_settle();
    test_counter_wrap();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream command stage for the 4-bit combinational ALU (operands A/B, selects S2..S0, 5-bit result Y).
- Accepts one command at a time over a valid/ready handshake and drives registered operands and selects into the ALU.
- Waits a programmable settle time, then captures Y and presents it downstream over a second valid/ready handshake.
- Supports chained operation: the low 4 bits of the last captured result can replace operand A, so multi-step computations run without a host round-trip.

Parameters:
SETTLE_CYCLES, 1, number of clock cycles ALU inputs are held before Y is captured; legal range 1..15.
COUNT_W, 8, width of completed-operation counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  3  ALU select {S2,S1,S0}.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
cmd_chain  input  1  use acc[3:0] as operand A instead of cmd_a.
alu_a  output  4  to ALU A.
alu_b  output  4  to ALU B.
alu_s2  output  1  to ALU S2.
alu_s1  output  1  to ALU S1.
alu_s0  output  1  to ALU S0.
alu_y  input  5  ALU result Y.
res_valid  output  1  result present.
res_ready  input  1  consumer accepts result.
res_y  output  5  captured result.
res_op  output  3  select that produced res_y.
busy  output  1  high whenever state is not IDLE.
op_count  output  COUNT_W  results handed off since reset.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - alu_a, alu_b, alu_s2/s1/s0, res_y, res_op, op_count all 0.
  - res_valid=0, busy=0, cmd_ready=1.
  - Internal acc=0, acc_valid=0, settle counter=0.
- States: IDLE, SETTLE, OUT. cmd_ready = (state==IDLE), combinational from state only.
- IDLE, on cmd_valid&&cmd_ready at edge k:
  - Register alu_b=cmd_b and {alu_s2,alu_s1,alu_s0}=cmd_op.
  - Register alu_a=acc[3:0] if (cmd_chain && acc_valid), else cmd_a. Chain with acc_valid=0 silently uses cmd_a.
  - Load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- IDLE without a handshake: alu_* hold their last values and never change.
- SETTLE:
  - Decrement the counter each cycle while it is nonzero.
  - On the edge where the counter is 0: capture res_y=alu_y, res_op=current select, acc=alu_y, acc_valid=1, res_valid=1; go to OUT.
  - With SETTLE_CYCLES=1, res_valid rises at edge k+1. In general it rises at edge k+SETTLE_CYCLES.
- OUT:
  - res_valid=1; res_y and res_op are stable until handshake.
  - On res_valid&&res_ready: res_valid=0, op_count increments, go to IDLE.
  - res_ready held low stalls indefinitely with no data change.
- Throughput: at most one command per SETTLE_CYCLES+2 cycles. cmd_ready is low in OUT, so there is no accept/handoff overlap; this one-cycle bubble is required.
- Inputs are ignored outside their handshake: cmd_* while cmd_ready=0, res_ready outside OUT.
- alu_* outputs keep their values through SETTLE and OUT.
- Width rules:
  - res_y is the full 5-bit Y, unmodified.
  - Chained A takes acc[3:0] only; acc[4] (carry) is dropped.
  - op_count wraps from 2^COUNT_W-1 to 0.
- Reset asserted mid-operation: immediate return to reset values and the in-flight result is discarded. acc_valid=0, so the first chain after reset uses cmd_a.

Test Plan:
- Basic add: SETTLE_CYCLES=1, op=000, A=F, B=1, res_ready=1. Expect cmd_ready low the cycle after accept, res_valid after 1 cycle, res_y=10h, res_op=000, op_count=1.
- Chain: op=010 A=7 (res_y=08h), then op=001 chain=1 cmd_a=3. Expect alu_a=8, res_y=10h. Then op=000 chain=1 B=1 uses acc[3:0]=0, giving res_y=01h.
- Backpressure: res_ready=0 for 5 cycles after res_valid. Expect res_valid, res_y, res_op stable, cmd_ready=0, cmd_valid ignored. After res_ready=1: one handoff, op_count +1, then IDLE.
- Settle timing: SETTLE_CYCLES=4, op=111 A=A B=5. Expect alu_* stable for 4 cycles, res_valid at accept+4, res_y=0Fh.
- Reset mid-SETTLE: assert rst_n=0 during SETTLE. Expect all outputs 0 and cmd_ready=1 immediately. A subsequent chain=1 command with cmd_a=2, op=010 gives res_y=03h.
- Counter wrap: COUNT_W=2, five completed ops → op_count sequence 1,2,3,0,1.
